argmax: RTL and testbench
=========================

Name: argmax

Overview:
- Registered argmax selector for the CNN classifier output stage.
- Takes N packed class scores of WIDTH bits each.
- Returns the index of the largest score and that score's value, one cycle after a valid input.
- Fully pipelined: accepts a new vector every cycle, with no backpressure.

Parameters:
- N, 4: number of elements; legal range is 2 or more.
- WIDTH, 16: bit width of each element.
- IDX_W, $clog2(N): index width; derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_vec is valid this cycle.
- in_vec  in  N*WIDTH  packed elements; element i = in_vec[i*WIDTH +: WIDTH], so element 0 is in the LSBs.
- out_valid  out  1  max_index/max_value are valid.
- max_index  out  IDX_W  index of the maximum element.
- max_value  out  WIDTH  value of the maximum element.

Behaviour:
- Reset: rst_n low clears out_valid, max_index and max_value to 0 immediately, without waiting for clk.
- Reset mid-operation: any in-flight result is discarded.
- Comparison: unsigned by default.
- Ties: the lowest index wins; a candidate replaces the current best only if it is strictly greater.
- Selection logic: combinational reduction over all N elements.
  - Either a linear scan or a balanced pairwise tree is acceptable.
  - In a tree, the left/lower-index operand wins ties, so the result is identical to a linear scan.
  - N need not be a power of 2; an odd element passes through unchanged to the next level.
- Latency: exactly 1 cycle.
  - At the rising edge where in_valid=1, out_valid<=1, and max_index/max_value <= the result for in_vec.
  - At an edge where in_valid=0, out_valid<=0, and max_index/max_value hold their previous values.
- Throughput: back-to-back valid inputs produce back-to-back outputs, one per cycle.
- All-equal inputs (including all zeros): max_index=0, max_value=that value.
- The index is always in the range 0..N-1.
- No X propagation from unused index codes when N is not a power of 2.

Optional Feature:
- Macro: ARGMAX_SIGNED_EN.
- Defined: elements are compared as two's-complement signed values, so 16'hFFFF (-1) is less than 16'd0. The tie rule and latency are unchanged.
- Undefined: unsigned comparison, so 16'hFFFF is the largest value.

Decomposition:
- No shared package is needed. IDX_W is a local derived constant. The element-extraction slice convention (element 0 in the LSBs) is shared with the producing FC layer and documented there as well.
- Sub-module argmax_cmp2:
  - Purely combinational.
  - Inputs: two (index, value) pairs. Output: the winning pair, following the strictly-greater rule with the lower index winning ties.
  - Compile-time signed/unsigned selection follows ARGMAX_SIGNED_EN.
  - The top level instantiates it in a generate loop or tree.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> out_valid, max_index and max_value go to 0 immediately; they stay 0 after release until the first valid input.
- Basic, N=4, WIDTH=16, one cycle each with in_valid=1 (elements listed index 0..3):
  - [7,5,20,10] -> next cycle max_index=2, max_value=20.
  - [30,25,50,1] -> max_index=2, max_value=50.
  - [90,80,20,100] -> max_index=3, max_value=100.
- Ties:
  - [9,9,3,9] -> max_index=0.
  - [0,0,0,0] -> max_index=0, max_value=0.
  - [1,4,4,2] -> max_index=1.
- Streaming: apply the three basic vectors on consecutive cycles -> outputs 2,2,3 on consecutive cycles with out_valid held high. Then drop in_valid -> out_valid=0 and the outputs hold 3/100.
- Sign handling: [16'hFFFF,1,0,2]:
  - Without the macro -> max_index=0, max_value=16'hFFFF.
  - With ARGMAX_SIGNED_EN -> max_index=3, max_value=2.
- Non-power-of-2 size: N=5, [3,8,1,8,12] -> max_index=4 (IDX_W=3); random regression against a reference model over 1000 vectors.

Source files
------------

// File: rtl/argmax_cmp2.sv
// Two-way (index, value) compare used by the argmax scan. The b side wins only
// when it is strictly greater, so the lower-index a side keeps ties.
// ARGMAX_SIGNED_EN selects two's-complement comparison; default is unsigned.
module argmax_cmp2 #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 2
) (
    input  logic [IDX_W-1:0] a_idx,
    input  logic [WIDTH-1:0] a_val,
    input  logic [IDX_W-1:0] b_idx,
    input  logic [WIDTH-1:0] b_val,
    output logic [IDX_W-1:0] win_idx,
    output logic [WIDTH-1:0] win_val
);

    logic b_gt;

`ifdef ARGMAX_SIGNED_EN
    assign b_gt = $signed(b_val) > $signed(a_val);
`else
    assign b_gt = b_val > a_val;
`endif

    assign win_idx = b_gt ? b_idx : a_idx;
    assign win_val = b_gt ? b_val : a_val;

endmodule

// File: rtl/argmax.sv
// Registered argmax over N packed scores (element 0 in the LSBs), 1-cycle latency.
// Signed comparison when ARGMAX_SIGNED_EN is defined (see argmax_cmp2).
module argmax #(
    parameter  int N     = 4,
    parameter  int WIDTH = 16,
    localparam int IDX_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [N*WIDTH-1:0] in_vec,
    output logic               out_valid,
    output logic [IDX_W-1:0]   max_index,
    output logic [WIDTH-1:0]   max_value
);

    logic [IDX_W-1:0] best_idx;
    logic [WIDTH-1:0] best_val;

    // Linear scan: stage i holds the best of elements 0..i. Indices only come
    // from genvar constants below N, so no unused code can ever appear.
    for (genvar i = 0; i < N; i++) begin : g_stage
        logic [IDX_W-1:0] stage_idx;
        logic [WIDTH-1:0] stage_val;

        if (i == 0) begin : g_first
            assign stage_idx = '0;
            assign stage_val = in_vec[0 +: WIDTH];
        end else begin : g_cmp
            argmax_cmp2 #(
                .WIDTH(WIDTH),
                .IDX_W(IDX_W)
            ) u_cmp (
                .a_idx  (g_stage[i-1].stage_idx),
                .a_val  (g_stage[i-1].stage_val),
                .b_idx  (IDX_W'(i)),
                .b_val  (in_vec[i*WIDTH +: WIDTH]),
                .win_idx(stage_idx),
                .win_val(stage_val)
            );
        end
    end

    assign best_idx = g_stage[N-1].stage_idx;
    assign best_val = g_stage[N-1].stage_val;

    // Result registers only load on valid input; otherwise they hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            max_index <= '0;
            max_value <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                max_index <= best_idx;
                max_value <= best_val;
            end
        end
    end

endmodule

// File: tb/tb_argmax.sv
// Self-checking bench for argmax: N=4 and N=5 instances against a reference
// model (maximum by value, then first index holding it).
module tb_argmax;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v4;
    logic [63:0] vec4;
    logic        ov4;
    logic [1:0]  mi4;
    logic [15:0] mv4;
    logic        v5;
    logic [79:0] vec5;
    logic        ov5;
    logic [2:0]  mi5;
    logic [15:0] mv5;

    argmax #(.N(4), .WIDTH(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_vec(vec4),
        .out_valid(ov4), .max_index(mi4), .max_value(mv4)
    );

    argmax #(.N(5), .WIDTH(16)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_vec(vec5),
        .out_valid(ov5), .max_index(mi5), .max_value(mv5)
    );

    int compared   = 0;
    int mismatched = 0;

    logic        e_v4, e_v5;
    int          e_i4, e_i5;
    logic [15:0] e_m4, e_m5;

    function automatic longint key(input logic [15:0] x);
`ifdef ARGMAX_SIGNED_EN
        return longint'($signed(x));
`else
        return longint'(x);
`endif
    endfunction

    // Find the maximum value first, then return the first index holding it.
    function automatic int ref_idx(input logic [79:0] vec, input int n);
        longint best;
        best = key(vec[15:0]);
        for (int k = 1; k < n; k++)
            if (key(vec[k*16 +: 16]) > best) best = key(vec[k*16 +: 16]);
        for (int k = 0; k < n; k++)
            if (key(vec[k*16 +: 16]) == best) return k;
        return -1;
    endfunction

    function automatic logic [63:0] pack4(input logic [15:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [79:0] pack5(input logic [15:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    function automatic logic [15:0] rand_elem(input int mode);
        logic [15:0] ext [4];
        ext[0] = 16'h0000; ext[1] = 16'hFFFF; ext[2] = 16'h8000; ext[3] = 16'h7FFF;
        case (mode)
            0:       return 16'($urandom_range(0, 3));
            2:       return ext[$urandom_range(0, 3)];
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " n4 out_valid"}, 32'(ov4), 32'(e_v4));
        check({tag, " n4 max_index"}, 32'(mi4), 32'(e_i4));
        check({tag, " n4 max_value"}, 32'(mv4), 32'(e_m4));
        check({tag, " n5 out_valid"}, 32'(ov5), 32'(e_v5));
        check({tag, " n5 max_index"}, 32'(mi5), 32'(e_i5));
        check({tag, " n5 max_value"}, 32'(mv5), 32'(e_m5));
    endtask

    task automatic model_reset();
        e_v4 = 1'b0; e_i4 = 0; e_m4 = '0;
        e_v5 = 1'b0; e_i5 = 0; e_m5 = '0;
    endtask

    // Drive both instances for one cycle, advance the model, check after the edge.
    task automatic step(input string tag, input logic a_v, input logic [63:0] a_vec,
                        input logic b_v, input logic [79:0] b_vec);
        v4 = a_v; vec4 = a_vec; v5 = b_v; vec5 = b_vec;
        @(posedge clk);
        e_v4 = a_v;
        if (a_v) begin
            e_i4 = ref_idx({16'd0, a_vec}, 4);
            e_m4 = a_vec[e_i4*16 +: 16];
        end
        e_v5 = b_v;
        if (b_v) begin
            e_i5 = ref_idx(b_vec, 5);
            e_m5 = b_vec[e_i5*16 +: 16];
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [63:0] r4;
        logic [79:0] r5;
        rst_n = 1'b0; v4 = 1'b0; vec4 = '0; v5 = 1'b0; vec5 = '0;
        model_reset();
        #1;
        check_all("reset_initial");
        #2 rst_n = 1'b1;
        step("idle_after_reset", 1'b0, '0, 1'b0, '0);

        // Basic vectors back-to-back (also the streaming case)
        step("basic0", 1'b1, pack4(16'd7, 16'd5, 16'd20, 16'd10), 1'b0, '0);
        check("basic0 const idx", 32'(mi4), 32'd2);
        check("basic0 const val", 32'(mv4), 32'd20);
        step("basic1", 1'b1, pack4(16'd30, 16'd25, 16'd50, 16'd1), 1'b0, '0);
        check("basic1 const idx", 32'(mi4), 32'd2);
        check("basic1 const val", 32'(mv4), 32'd50);
        check("stream valid1", 32'(ov4), 32'd1);
        step("basic2", 1'b1, pack4(16'd90, 16'd80, 16'd20, 16'd100), 1'b0, '0);
        check("basic2 const idx", 32'(mi4), 32'd3);
        check("basic2 const val", 32'(mv4), 32'd100);
        check("stream valid2", 32'(ov4), 32'd1);
        step("drop_valid", 1'b0, pack4(16'd500, 16'd0, 16'd0, 16'd0), 1'b0, '0);
        check("hold valid", 32'(ov4), 32'd0);
        check("hold idx", 32'(mi4), 32'd3);
        check("hold val", 32'(mv4), 32'd100);

        // Ties
        step("tie_9", 1'b1, pack4(16'd9, 16'd9, 16'd3, 16'd9), 1'b0, '0);
        check("tie_9 const idx", 32'(mi4), 32'd0);
        step("tie_zero", 1'b1, pack4(16'd0, 16'd0, 16'd0, 16'd0), 1'b0, '0);
        check("tie_zero const idx", 32'(mi4), 32'd0);
        check("tie_zero const val", 32'(mv4), 32'd0);
        step("tie_4", 1'b1, pack4(16'd1, 16'd4, 16'd4, 16'd2), 1'b0, '0);
        check("tie_4 const idx", 32'(mi4), 32'd1);

        // Sign handling
        step("sign", 1'b1, pack4(16'hFFFF, 16'd1, 16'd0, 16'd2), 1'b0, '0);
`ifdef ARGMAX_SIGNED_EN
        check("sign const idx", 32'(mi4), 32'd3);
        check("sign const val", 32'(mv4), 32'd2);
`else
        check("sign const idx", 32'(mi4), 32'd0);
        check("sign const val", 32'(mv4), 32'hFFFF);
`endif

        // Non-power-of-2 size
        step("n5_basic", 1'b0, '0, 1'b1, pack5(16'd3, 16'd8, 16'd1, 16'd8, 16'd12));
        check("n5 const idx", 32'(mi5), 32'd4);
        check("n5 const val", 32'(mv5), 32'd12);
        step("n5_tie", 1'b0, '0, 1'b1, pack5(16'd2, 16'd8, 16'd1, 16'd8, 16'd8));
        check("n5_tie const idx", 32'(mi5), 32'd1);

        // Asynchronous reset mid-cycle discards an in-flight valid input
        v4 = 1'b1; vec4 = pack4(16'd1, 16'd2, 16'd3, 16'd4);
        v5 = 1'b1; vec5 = pack5(16'd5, 16'd4, 16'd3, 16'd2, 16'd1);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset_async");
        @(posedge clk);
        #1;
        check_all("reset_held");
        #2 rst_n = 1'b1;
        step("reset_release", 1'b0, '0, 1'b0, '0);

        // Random regression
        for (int t = 0; t < 1000; t++) begin
            for (int k = 0; k < 4; k++) r4[k*16 +: 16] = rand_elem($urandom_range(0, 3));
            for (int k = 0; k < 5; k++) r5[k*16 +: 16] = rand_elem($urandom_range(0, 3));
            step("random", 1'($urandom_range(0, 3) != 0), r4,
                 1'($urandom_range(0, 3) != 0), r5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
